// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer block: register offsets, bus FSM states
// and the ctrl register bit layout.
package bus_timer_pkg;

  localparam logic [4:0] MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] CTRL        = 5'h10;
  localparam logic [4:0] PRESCALE    = 5'h14;

  localparam int CTRL_ENABLE_BIT = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_timer_prescaler.sv
// Tick generator for bus_timer: one tick every (prescale + 1) enabled cycles.
// Only instantiated when BUS_TIMER_PRESCALER_EN is defined.
module bus_timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      clear,
  output logic                      tick
);

  localparam logic [PRESCALE_WIDTH-1:0] CNT_ZERO = {PRESCALE_WIDTH{1'b0}};
  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  logic [PRESCALE_WIDTH-1:0] count_r;
  logic                      match_s;

  assign match_s = (count_r == prescale);
  assign tick    = enable && match_s;

  // Cycle counter, parked at zero while disabled or when the prescale is rewritten
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
    end else if (!enable || clear) begin
      count_r <= CNT_ZERO;
    end else if (match_s) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 64-bit machine timer with compare interrupt, served over
// a request/ready bus. Define BUS_TIMER_PRESCALER_EN to add the tick prescaler.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [4:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt
);

  bus_state_e                state_r;
  bus_state_e                state_next_s;
  logic                      ready_next_s;
  logic                      ready_r;
  logic [31:0]               rdata_r;
  logic [31:0]               read_mux_s;
  logic                      irq_r;
  logic [63:0]               mtime_r;
  logic [63:0]               mtimecmp_r;
  logic                      enable_r;
  logic [31:0]               hi_shadow_r;
  logic                      tick_s;
  logic                      wr_s;
  logic                      rd_s;
  logic [4:0]                addr_s;
  logic                      addr_unused_s;
  logic [PRESCALE_WIDTH-1:0] prescale_view_s;

  assign addr_s        = {i_address[4:2], 2'b00};
  assign addr_unused_s = ^i_address[1:0];

  assign o_ready     = ready_r;
  assign o_rdata     = rdata_r;
  assign o_interrupt = irq_r;

  // Bus FSM state register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus FSM next state: RELEASE waits for the initiator to drop its request
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_request) state_next_s = ACK;
        else           state_next_s = IDLE;
      end
      ACK:     state_next_s = RELEASE;
      RELEASE: begin
        if (!i_request) state_next_s = IDLE;
        else            state_next_s = RELEASE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Bus FSM outputs: access strobes in IDLE and the next-cycle ready
  always_comb begin
    ready_next_s = (state_next_s == ACK);
    if ((state_r == IDLE) && i_request) begin
      wr_s = i_rw;
      rd_s = !i_rw;
    end else begin
      wr_s = 1'b0;
      rd_s = 1'b0;
    end
  end

  // Read data selection by word offset
  always_comb begin
    read_mux_s = 32'h0000_0000;
    case (addr_s)
      MTIME_LO:    read_mux_s = mtime_r[31:0];
      MTIME_HI:    read_mux_s = hi_shadow_r;
      MTIMECMP_LO: read_mux_s = mtimecmp_r[31:0];
      MTIMECMP_HI: read_mux_s = mtimecmp_r[63:32];
      CTRL:        read_mux_s[CTRL_ENABLE_BIT] = enable_r;
      PRESCALE:    read_mux_s = 32'(prescale_view_s);
      default:     read_mux_s = 32'h0000_0000;
    endcase
  end

  // Bus response registers; read data exists only in the ready cycle
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      ready_r <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ready_r <= ready_next_s;
      rdata_r <= rd_s ? read_mux_s : 32'h0000_0000;
    end
  end

  // Compare, control and high-half shadow registers
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
      enable_r    <= 1'b0;
      hi_shadow_r <= 32'h0000_0000;
    end else begin
      if (wr_s && (addr_s == MTIMECMP_LO)) mtimecmp_r[31:0]  <= i_wdata;
      if (wr_s && (addr_s == MTIMECMP_HI)) mtimecmp_r[63:32] <= i_wdata;
      if (wr_s && (addr_s == CTRL))        enable_r          <= i_wdata[CTRL_ENABLE_BIT];
      // Latching the high half on a low-half read gives the CPU a coherent 64-bit snapshot
      if (rd_s && (addr_s == MTIME_LO))    hi_shadow_r       <= mtime_r[63:32];
    end
  end

  // mtime counter: a bus write to either half suppresses that cycle's tick entirely
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      mtime_r <= 64'h0000_0000_0000_0000;
    end else if (wr_s && (addr_s == MTIME_LO)) begin
      mtime_r <= {mtime_r[63:32], i_wdata};
    end else if (wr_s && (addr_s == MTIME_HI)) begin
      mtime_r <= {i_wdata, mtime_r[31:0]};
    end else if (tick_s) begin
      mtime_r <= mtime_r + 64'd1;
    end else begin
      mtime_r <= mtime_r;
    end
  end

  // Timer interrupt comparator
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= enable_r && (mtime_r >= mtimecmp_r);
    end
  end

`ifdef BUS_TIMER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic                      prescale_wr_s;

  assign prescale_wr_s   = wr_s && (addr_s == PRESCALE);
  assign prescale_view_s = prescale_r;

  // Prescale divider register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      prescale_r <= {PRESCALE_WIDTH{1'b0}};
    end else if (prescale_wr_s) begin
      prescale_r <= i_wdata[PRESCALE_WIDTH-1:0];
    end else begin
      prescale_r <= prescale_r;
    end
  end

  bus_timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clock   (i_clock),
    .reset   (i_reset),
    .enable  (enable_r),
    .prescale(prescale_r),
    .clear   (prescale_wr_s),
    .tick    (tick_s)
  );
`else
  assign prescale_view_s = {PRESCALE_WIDTH{1'b0}};
  assign tick_s          = enable_r;
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Testbench for bus_timer: randomized and directed bus traffic, scoreboard of read
// data against a cycle-level register model, continuous interrupt comparison.
module tb_bus_timer;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [4:0]  i_address = 5'h00;
  logic [31:0] i_wdata = 32'h0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_interrupt;

  bus_timer dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_request  (i_request),
    .i_rw       (i_rw),
    .i_address  (i_address),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_ready    (o_ready),
    .o_interrupt(o_interrupt)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [31:0] m_shadow;
  logic [15:0] m_prescale;
  int          m_pcount;
  logic        m_irq;

  // Pending access handed from the bus driver to the model
  logic        access_now = 1'b0;
  logic        acc_rw;
  logic [4:0]  acc_addr;
  logic [31:0] acc_wdata;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  bit          mon_en = 1'b0;

  logic        t_tick;
  logic        t_irq;
  logic        t_wr_mtime;
  logic [4:0]  t_wa;
  logic [31:0] t_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: applies the register-map rules at every rising edge
  initial begin
    forever begin
      @(posedge i_clock);
      if (!i_reset) begin
        m_mtime = 64'h0; m_cmp = '1; m_en = 1'b0; m_shadow = 32'h0;
        m_prescale = 16'h0; m_pcount = 0; m_irq = 1'b0; access_now = 1'b0;
      end else begin
`ifdef BUS_TIMER_PRESCALER_EN
        t_tick = m_en && (m_pcount == int'(m_prescale));
        if (!m_en || t_tick) m_pcount = 0;
        else                 m_pcount = m_pcount + 1;
`else
        t_tick = m_en;
`endif
        t_irq = m_en && (m_mtime >= m_cmp);
        t_wr_mtime = 1'b0;
        if (access_now) begin
          access_now = 1'b0;
          t_wa = {acc_addr[4:2], 2'b00};
          if (!acc_rw) begin
            t_rd = 32'h0;
            case (t_wa)
              5'h00: begin t_rd = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
              5'h04: t_rd = m_shadow;
              5'h08: t_rd = m_cmp[31:0];
              5'h0C: t_rd = m_cmp[63:32];
              5'h10: t_rd = {31'h0, m_en};
`ifdef BUS_TIMER_PRESCALER_EN
              5'h14: t_rd = {16'h0, m_prescale};
`endif
              default: t_rd = 32'h0;
            endcase
            exp_q.push_back(t_rd);
          end else begin
            exp_q.push_back(32'h0);
            case (t_wa)
              5'h00: begin m_mtime[31:0]  = acc_wdata; t_wr_mtime = 1'b1; end
              5'h04: begin m_mtime[63:32] = acc_wdata; t_wr_mtime = 1'b1; end
              5'h08: m_cmp[31:0]  = acc_wdata;
              5'h0C: m_cmp[63:32] = acc_wdata;
              5'h10: m_en = acc_wdata[0];
`ifdef BUS_TIMER_PRESCALER_EN
              5'h14: begin m_prescale = acc_wdata[15:0]; m_pcount = 0; end
`endif
              default: ;
            endcase
          end
        end
        if (!t_wr_mtime && t_tick) m_mtime = m_mtime + 64'd1;
        m_irq = t_irq;
      end
    end
  end

  // Monitor: pops the scoreboard on every ready, checks idle data and interrupt
  initial begin
    forever begin
      @(negedge i_clock);
      if (mon_en) begin
        check("interrupt", {63'h0, o_interrupt}, {63'h0, m_irq});
        if (o_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 64'h1, 64'h0);
          end else begin
            mon_exp = exp_q.pop_front();
            check("rdata", {32'h0, o_rdata}, {32'h0, mon_exp});
          end
        end else begin
          check("rdata_idle", {32'h0, o_rdata}, 64'h0);
        end
      end
    end
  end

  task automatic bus(input logic rw, input logic [4:0] addr, input logic [31:0] wdata,
                     input int hold);
    int waits;
    int readies;
    @(negedge i_clock);
    i_request = 1'b1; i_rw = rw; i_address = addr; i_wdata = wdata;
    acc_rw = rw; acc_addr = addr; acc_wdata = wdata; access_now = 1'b1;
    waits = 0;
    do begin
      @(negedge i_clock);
      waits++;
    end while (o_ready !== 1'b1 && waits < 8);
    check("ready_latency", waits, 1);
    readies = (o_ready === 1'b1) ? 1 : 0;
    repeat (hold) begin
      @(negedge i_clock);
      if (o_ready === 1'b1) readies++;
    end
    check("single_ready", readies, 1);
    i_request = 1'b0;
    @(negedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic do_reset(input int n);
    @(negedge i_clock);
    i_reset = 1'b0; i_request = 1'b0;
    repeat (n) @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clock);
    check("reset_ready", {63'h0, o_ready}, 64'h0);
    check("reset_irq", {63'h0, o_interrupt}, 64'h0);
    i_reset = 1'b1;
    mon_en = 1'b1;
    bus(1'b0, 5'h08, 32'h0, 0);
    bus(1'b0, 5'h0C, 32'h0, 0);

    // Handshake with a long-held request
    bus(1'b0, 5'h10, 32'h0, 4);

    // Counter / compare
    bus(1'b1, 5'h08, 32'h10, 0);
    bus(1'b1, 5'h0C, 32'h0, 0);
    bus(1'b1, 5'h10, 32'h1, 0);
    repeat (25) @(negedge i_clock);
    check("irq_raised", {63'h0, o_interrupt}, 64'h1);
    bus(1'b1, 5'h0C, 32'h1, 0);
    check("irq_cleared", {63'h0, o_interrupt}, 64'h0);

    // Wrap and high-half shadow
    bus(1'b1, 5'h10, 32'h0, 0);
    bus(1'b1, 5'h00, 32'hFFFF_FFFE, 0);
    bus(1'b1, 5'h04, 32'hFFFF_FFFF, 0);
    bus(1'b1, 5'h10, 32'h1, 0);
    bus(1'b0, 5'h00, 32'h0, 0);
    bus(1'b0, 5'h04, 32'h0, 0);

    // Write/tick collision on the low half
    bus(1'b1, 5'h00, 32'h100, 0);
    bus(1'b0, 5'h00, 32'h0, 0);
    bus(1'b1, 5'h04, 32'h7, 0);
    bus(1'b0, 5'h00, 32'h0, 1);
    bus(1'b0, 5'h04, 32'h0, 0);

`ifdef BUS_TIMER_PRESCALER_EN
    bus(1'b1, 5'h10, 32'h0, 0);
    bus(1'b1, 5'h00, 32'h0, 0);
    bus(1'b1, 5'h04, 32'h0, 0);
    bus(1'b1, 5'h14, 32'h3, 0);
    bus(1'b0, 5'h14, 32'h0, 0);
    bus(1'b1, 5'h10, 32'h1, 0);
    repeat (37) @(negedge i_clock);
    bus(1'b0, 5'h00, 32'h0, 0);
    bus(1'b1, 5'h14, 32'h0, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge i_clock);
      bus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          int'($urandom_range(0, 2)));
    end

    // Reset during the ready cycle of a mtimecmp write
    @(negedge i_clock);
    i_request = 1'b1; i_rw = 1'b1; i_address = 5'h08; i_wdata = 32'h1234;
    acc_rw = 1'b1; acc_addr = 5'h08; acc_wdata = 32'h1234; access_now = 1'b1;
    @(negedge i_clock);
    check("ack_before_reset", {63'h0, o_ready}, 64'h1);
    i_reset = 1'b0;
    @(negedge i_clock);
    check("ready_after_reset", {63'h0, o_ready}, 64'h0);
    i_request = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    bus(1'b0, 5'h08, 32'h0, 0);
    bus(1'b0, 5'h0C, 32'h0, 0);
    bus(1'b0, 5'h10, 32'h0, 0);

    repeat (3) @(negedge i_clock);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
